// File: rtl/uart_pkg.sv
// Shared UART definitions: frame data width and transmitter/receiver state encodings.
package uart_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_txd.sv
// UART transmitter: serialises one byte per accepted request as start, data LSB first,
// optional parity and one or two stop bits, advancing only on external baud pulses.
module uart_txd
    import uart_pkg::*;
#(
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic              uart_clk,
    input  logic              uart_rst_n,
    input  logic              uart_tx_enable,
    input  logic              tx_baud_clk,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] para_data,
    output logic              tx_ready,
    output logic              tx_clk_en,
    output logic              rs232_txd,
    output logic              tx_done
);

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e          state;
    logic [DATA_W-1:0]    shift_reg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 stop_cnt;
    logic                 parity_bit;

    // Frame sequencer; every output is a register updated with the state.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            tx_ready   <= 1'b1;
            tx_clk_en  <= 1'b0;
            rs232_txd  <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rs232_txd <= 1'b1;
                    tx_ready  <= 1'b1;
                    if (tx_ready && tx_start && uart_tx_enable) begin
                        shift_reg  <= para_data;
                        parity_bit <= (^para_data) ^ PARITY_ODD;
                        tx_ready   <= 1'b0;
                        tx_clk_en  <= 1'b1;
                        rs232_txd  <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_baud_clk) begin
                        rs232_txd <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_baud_clk) begin
                        // Counter wraps 7->0 on the way out so the next frame starts clean.
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
                            if (PARITY_EN) begin
                                rs232_txd <= parity_bit;
                                state     <= ST_PARITY;
                            end else begin
                                rs232_txd <= 1'b1;
                                state     <= ST_STOP;
                            end
                        end else begin
                            rs232_txd <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tx_baud_clk) begin
                        rs232_txd <= 1'b1;
                        state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tx_baud_clk) begin
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt  <= 1'b0;
                            tx_done   <= 1'b1;
                            tx_clk_en <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    rs232_txd <= 1'b1;
                    tx_clk_en <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txd.sv
// Randomised scoreboard bench for uart_txd: three configurations share stimulus, each
// checked cycle by cycle against an expected bit list built from the frame format.
module tb_uart_txd;

    localparam int NCH = 3;
    localparam bit CH_PEN  [NCH] = '{1'b0, 1'b1, 1'b1};
    localparam bit CH_ODD  [NCH] = '{1'b0, 1'b0, 1'b1};
    localparam int CH_STOP [NCH] = '{1, 2, 1};

    typedef struct packed {
        logic [11:0] bits;
        int unsigned n;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic start;
    logic [7:0] data;
    logic [NCH-1:0] baud, ready, clk_en, txd, done;

    int checks = 0;
    int errors = 0;
    int unsigned bit_period = 16;
    int unsigned bcnt [NCH];
    int unsigned acc_cnt [NCH];
    frame_t sb [NCH][$];

    logic   act     [NCH];
    logic   adv     [NCH];
    logic   cur_bit [NCH];
    int     idx     [NCH];
    frame_t cur_f   [NCH];

    always #5 clk = ~clk;

    uart_txd #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut0 (
        .uart_clk(clk), .uart_rst_n(rst_n), .uart_tx_enable(en), .tx_baud_clk(baud[0]),
        .tx_start(start), .para_data(data), .tx_ready(ready[0]), .tx_clk_en(clk_en[0]),
        .rs232_txd(txd[0]), .tx_done(done[0]));
    uart_txd #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut1 (
        .uart_clk(clk), .uart_rst_n(rst_n), .uart_tx_enable(en), .tx_baud_clk(baud[1]),
        .tx_start(start), .para_data(data), .tx_ready(ready[1]), .tx_clk_en(clk_en[1]),
        .rs232_txd(txd[1]), .tx_done(done[1]));
    uart_txd #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut2 (
        .uart_clk(clk), .uart_rst_n(rst_n), .uart_tx_enable(en), .tx_baud_clk(baud[2]),
        .tx_start(start), .para_data(data), .tx_ready(ready[2]), .tx_clk_en(clk_en[2]),
        .rs232_txd(txd[2]), .tx_done(done[2]));

    function automatic void check(string nm, int ch, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s ch%0d t=%0t: got %b expected %b", nm, ch, $time, got, exp);
        end
    endfunction

    // Expected line sequence for one byte: start, data LSB first, parity, stop bits.
    function automatic frame_t make_frame(int ch, logic [7:0] d);
        frame_t f;
        int ones = 0;
        f.bits = '0;
        f.n = 0;
        f.bits[f.n] = 1'b0; f.n++;
        for (int k = 0; k < 8; k++) begin
            f.bits[f.n] = d[k]; f.n++;
            ones += int'(d[k]);
        end
        if (CH_PEN[ch]) begin
            f.bits[f.n] = ((ones % 2) == 1) ^ CH_ODD[ch]; f.n++;
        end
        for (int s = 0; s < CH_STOP[ch]; s++) begin
            f.bits[f.n] = 1'b1; f.n++;
        end
        return f;
    endfunction

    // External baud generators, restarted whenever tx_clk_en is low.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!clk_en[i]) begin
                bcnt[i] <= 0;
                baud[i] <= 1'b0;
            end else if (bcnt[i] >= bit_period - 1) begin
                bcnt[i] <= 0;
                baud[i] <= 1'b1;
            end else begin
                bcnt[i] <= bcnt[i] + 1;
                baud[i] <= 1'b0;
            end
        end
    end

    // Scoreboard producer: each accepted request queues its expected frame.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n) acc_cnt[i] = 0;
            else if (ready[i] && start && en) begin
                sb[i].push_back(make_frame(i, data));
                acc_cnt[i]++;
            end
        end
    end

    // Monitor: compares line, ready, clk_en and done against the queued frames.
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n) begin
                act[i] = 1'b0;
                sb[i].delete();
                check("rst_txd", i, txd[i], 1'b1);
                check("rst_clk_en", i, clk_en[i], 1'b0);
                check("rst_done", i, done[i], 1'b0);
            end else if (act[i]) begin
                if (adv[i] && idx[i] == int'(cur_f[i].n)) begin
                    check("done_pulse", i, done[i], 1'b1);
                    check("done_txd", i, txd[i], 1'b1);
                    check("done_clk_en", i, clk_en[i], 1'b0);
                    check("done_ready", i, ready[i], 1'b0);
                    act[i] = 1'b0;
                end else begin
                    if (adv[i]) begin
                        cur_bit[i] = cur_f[i].bits[idx[i]];
                        idx[i]++;
                    end
                    check(adv[i] ? "line_bit" : "line_hold", i, txd[i], cur_bit[i]);
                    check("busy_done", i, done[i], 1'b0);
                    check("busy_ready", i, ready[i], 1'b0);
                    check("busy_clk_en", i, clk_en[i], 1'b1);
                end
            end else if (sb[i].size() > 0) begin
                cur_f[i] = sb[i].pop_front();
                act[i] = 1'b1;
                idx[i] = 1;
                cur_bit[i] = 1'b0;
                check("start_txd", i, txd[i], 1'b0);
                check("start_ready", i, ready[i], 1'b0);
                check("start_clk_en", i, clk_en[i], 1'b1);
            end else begin
                check("idle_txd", i, txd[i], 1'b1);
                check("idle_done", i, done[i], 1'b0);
                check("idle_clk_en", i, clk_en[i], 1'b0);
                check("idle_ready", i, ready[i], 1'b1);
            end
            adv[i] = baud[i];
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_all(logic [7:0] d);
        int unsigned snap [NCH];
        bit all;
        int t = 0;
        for (int i = 0; i < NCH; i++) snap[i] = acc_cnt[i];
        data = d;
        start = 1'b1;
        do begin
            tick(1);
            t++;
            all = 1'b1;
            for (int i = 0; i < NCH; i++) if (acc_cnt[i] == snap[i]) all = 1'b0;
        end while (!all && t < 3000);
        check("accept_timeout", 0, all, 1'b1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit busy;
        int t = 0;
        do begin
            tick(1);
            t++;
            busy = 1'b0;
            for (int i = 0; i < NCH; i++) if (act[i] || sb[i].size() > 0) busy = 1'b1;
        end while (busy && t < 5000);
        check("idle_timeout", 0, busy, 1'b0);
        tick(2);
    endtask

    task automatic wait_idx0(int target);
        int t = 0;
        while (!(act[0] && idx[0] >= target) && t < 1000) begin
            tick(1);
            t++;
        end
        check("idx_timeout", 0, act[0] && idx[0] >= target, 1'b1);
    endtask

    initial begin
        int unsigned snap [NCH];
        rst_n = 1'b0;
        en = 1'b0;
        start = 1'b0;
        data = 8'h00;
        tick(4);
        rst_n = 1'b1;
        en = 1'b1;
        tick(3);

        send_all(8'h55); wait_idle();
        send_all(8'h07); wait_idle();
        send_all(8'h03); wait_idle();

        // Busy rejection and mid-frame data changes.
        send_all(8'h0F);
        wait_idx0(4);
        data = 8'hAA; start = 1'b1; tick(1); start = 1'b0;
        data = 8'h5A; tick(20); data = 8'hFF;
        wait_idle();

        // Back-to-back: start held so the second byte lands in the first ready cycle.
        send_all(8'h01); send_all(8'h80); wait_idle();

        // Enable dropped during START: frame completes, held start is ignored.
        send_all(8'hC3);
        en = 1'b0;
        for (int i = 0; i < NCH; i++) snap[i] = acc_cnt[i];
        start = 1'b1; data = 8'h3C;
        tick(700);
        for (int i = 0; i < NCH; i++) check("enable_low_accept", i, acc_cnt[i] == snap[i], 1'b1);
        en = 1'b1;
        send_all(8'h3C); wait_idle();

        // Reset during d3 aborts every frame at once.
        send_all(8'($urandom));
        wait_idx0(5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NCH; i++) begin
            check("abort_txd", i, txd[i], 1'b1);
            check("abort_clk_en", i, clk_en[i], 1'b0);
            check("abort_done", i, done[i], 1'b0);
        end
        tick(3);
        rst_n = 1'b1;
        tick(40);

        // Random traffic: data, start, enable and bit period all varied.
        for (int blk = 0; blk < 6; blk++) begin
            bit_period = $urandom_range(12, 3);
            for (int it = 0; it < 60; it++) begin
                data = 8'($urandom);
                start = ($urandom_range(3, 0) == 0);
                en = ($urandom_range(7, 0) != 0);
                tick($urandom_range(12, 1));
            end
        end
        start = 1'b0;
        en = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
